mac_pe_simd: RTL and testbench
==============================

// Module: mac_pe_simd
// PURPOSE
//  Next-generation systolic processing element (PE) with LANES parallel MAC lanes per PE.
//  - One activation stream on the X axis (left to right) is broadcast to all lanes.
//  - Each lane holds its own double-buffered weight.
//  - Y carries LANES partial sums packed into one word (top to bottom).
//  - Elastic valid/ready on X and Y; X and Y fork/join the same way as the scalar PE.
//  - Adds over the scalar PE: a runtime unsigned-activation mode and a shadow-full status flag.
// PARAMETERS
//  DATA_WIDTH  8   activation/weight width; weights are always signed
//  ACC_WIDTH   32  per-lane accumulator width; must be >= 2*DATA_WIDTH+2
//  LANES       4   number of parallel MAC lanes (>=1)
// PORTS
//  clk              in   1                clock, rising edge
//  rst_n            in   1                asynchronous active-low reset
//  valid_in_x       in   1                X token valid
//  ready_out_x      out  1                X token accepted (= fire)
//  weight_shift_in  in   1                X token is a weight-load token
//  x_in             in   DATA_WIDTH       activation or weight
//  valid_out_x      out  1                downstream X valid
//  ready_in_x       in   1                downstream X ready
//  weight_shift_out out  1                forwarded weight-load flag
//  x_out            out  DATA_WIDTH       forwarded activation / evicted weight
//  valid_in_y       in   1                Y partial-sum valid
//  ready_out_y      out  1                Y accepted (= fire_calc)
//  y_in             in   LANES*ACC_WIDTH  packed partial sums; lane i = [i*ACC_WIDTH +: ACC_WIDTH]
//  valid_out_y      out  1                downstream Y valid
//  ready_in_y       in   1                downstream Y ready
//  y_out            out  LANES*ACC_WIDTH  packed updated sums
//  weight_latch_en  in   1                copy all shadow weights to active weights
//  x_unsigned       in   1                1: treat x_in as unsigned in MAC
//  shadow_full      out  1                at least LANES load tokens accepted since last latch
// BEHAVIOUR
//  Reset: all outputs 0; all weights 0; load counter 0.
//  Handshake:
//   - stall_x = valid_out_x & ~ready_in_x; stall_y = valid_out_y & ~ready_in_y.
//   - fire_load = valid_in_x & weight_shift_in & ~stall_x. Y is ignored.
//   - fire_calc = valid_in_x & valid_in_y & ~weight_shift_in & ~stall_x & ~stall_y.
//   - Inputs are combinational to the ready outputs; no path from ready_in_* to ready_out_* other than through the stall terms.
//  Weight load (on fire_load):
//   - shadow[0] <= x_in; shadow[i] <= shadow[i-1]; x_out <= shadow[LANES-1].
//   - valid_out_x <= 1; weight_shift_out <= 1; valid_out_y <= 0.
//   - Load counter increments and saturates at LANES.
//  Calc (on fire_calc), latency 1 cycle:
//   - x_out <= x_in; weight_shift_out <= 0; valid_out_x <= 1; valid_out_y <= 1.
//   - Lane i: y_out_i <= y_in_i + ext(xe * active[i]).
//   - xe = x_in extended to DATA_WIDTH+1 bits: zero-extended if x_unsigned, else sign-extended.
//   - The signed product is sign-extended to ACC_WIDTH.
//   - Without SAT the sum wraps modulo 2^ACC_WIDTH.
//  Idle: a valid_out flag clears when it is consumed (valid & ready) and no new fire occurs; data registers hold.
//  Latch: when weight_latch_en=1, active[i] <= shadow[i] (pre-shift values if fire_load happens in the same cycle) and the load counter resets to 0.
//   - If latch and load coincide, the counter is set to 1 (the current token counts).
//  shadow_full: registered, = (count == LANES).
//  Reset asserted mid-operation: immediate clear; in-flight tokens are lost.
// CONFIGURATION
//  MAC_PE_SIMD_SAT_EN defined:
//   - Each lane sum saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
//   - Overflow is detected from the operand signs vs the result sign.
//  MAC_PE_SIMD_SAT_EN undefined: two's-complement wrap. Timing and handshake are identical in both builds.
// STRUCTURE
//  Package npu_pkg:
//   - NPU_DATA_WIDTH and NPU_ACC_WIDTH defaults.
//   - Function sat_add(a, b) and a lane-slice helper macro.
//  Sub-module mac_lane (one per lane, generate loop):
//   - Owns shadow/active registers, multiply, extend and add (plus saturation).
//   - Exposes the shadow value for chaining.
//  Top level holds the handshake, the X/Y output registers and the load counter.
// TESTING
//  1. LANES=4: shift weights 1,2,3,4 (4 load tokens), latch -> active = {4,3,2,1} lane0..3; shadow_full=1 before the latch, 0 after.
//  2. After test 1: x_in=3, y_in all 10 -> next cycle y_out lanes = 22,19,16,13; valid_out_x/y=1.
//  3. x_in=8'hFF, weight -1:
//     - x_unsigned=0 -> product +1.
//     - x_unsigned=1 -> product -255.
//     - Check with y_in=0.
//  4. ready_in_y=0 with valid_out_y=1 -> ready_out_x=ready_out_y=0 for a calc token; a weight-load token is still accepted if X is not stalled.
//  5. y_in=32'h7FFF_FFFF, x=1, w=1:
//     - SAT_EN -> 32'h7FFF_FFFF.
//     - Without -> 32'h8000_0000.
//  6. Assert weight_latch_en in the same cycle as fire_load -> active takes pre-shift shadow, counter=1; rst_n low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU definitions: default widths, saturating add and a lane-slice helper macro.
// NPU_LANE(i, w) expands to the part-select of lane i in a packed vector of w-bit lanes.
`define NPU_LANE(i, w) (i)*(w) +: (w)

package npu_pkg;

    localparam int unsigned NPU_DATA_WIDTH = 8;
    localparam int unsigned NPU_ACC_WIDTH  = 32;

    // Signed add of two w-bit values held in the low bits; clamps on overflow (w <= 64).
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic [63:0] sum;
        logic [63:0] max_v;
        logic [63:0] min_v;
        logic        sa;
        logic        sb;
        logic        sr;
        sum   = a + b;
        sa    = a[w-1];
        sb    = b[w-1];
        sr    = sum[w-1];
        max_v = (64'd1 << (w - 1)) - 64'd1;
        min_v = 64'd1 << (w - 1);
        if ((sa == sb) && (sr != sa)) begin
            return sa ? min_v : max_v;
        end
        return sum;
    endfunction

endpackage

// File: rtl/mac_pe_simd_if.sv
// X/Y stream, weight control and status bundle of the SIMD MAC PE.
interface mac_pe_simd_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned LANES      = 4
);
    logic                         valid_in_x;
    logic                         ready_out_x;
    logic                         weight_shift_in;
    logic [DATA_WIDTH-1:0]        x_in;
    logic                         valid_out_x;
    logic                         ready_in_x;
    logic                         weight_shift_out;
    logic [DATA_WIDTH-1:0]        x_out;
    logic                         valid_in_y;
    logic                         ready_out_y;
    logic [LANES*ACC_WIDTH-1:0]   y_in;
    logic                         valid_out_y;
    logic                         ready_in_y;
    logic [LANES*ACC_WIDTH-1:0]   y_out;
    logic                         weight_latch_en;
    logic                         x_unsigned;
    logic                         shadow_full;

    modport slave (
        input  valid_in_x, weight_shift_in, x_in, ready_in_x, valid_in_y, y_in, ready_in_y,
               weight_latch_en, x_unsigned,
        output ready_out_x, valid_out_x, weight_shift_out, x_out, ready_out_y, valid_out_y,
               y_out, shadow_full
    );

    modport master (
        output valid_in_x, weight_shift_in, x_in, ready_in_x, valid_in_y, y_in, ready_in_y,
               weight_latch_en, x_unsigned,
        input  ready_out_x, valid_out_x, weight_shift_out, x_out, ready_out_y, valid_out_y,
               y_out, shadow_full
    );
endinterface

// File: rtl/mac_lane.sv
// One MAC lane: double-buffered signed weight and a combinational multiply-accumulate.
// MAC_PE_SIMD_SAT_EN selects a saturating accumulate instead of two's-complement wrap.
module mac_lane
    import npu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = NPU_DATA_WIDTH,
    parameter int unsigned ACC_WIDTH  = NPU_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  latch_i,
    input  logic                  x_unsigned_i,
    input  logic [DATA_WIDTH-1:0] shadow_in_i,
    input  logic [DATA_WIDTH-1:0] x_i,
    input  logic [ACC_WIDTH-1:0]  y_i,
    output logic [DATA_WIDTH-1:0] shadow_o,
    output logic [ACC_WIDTH-1:0]  sum_o
);
    localparam int unsigned PW = 2 * DATA_WIDTH + 1;

    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [DATA_WIDTH-1:0] active_q, active_d;
    logic signed [DATA_WIDTH:0] xe;
    logic signed [PW-1:0]       prod;
    logic [ACC_WIDTH-1:0]       prod_ext;
`ifdef MAC_PE_SIMD_SAT_EN
    logic [63:0]                sum_wide;
`endif

    // Latch copies the pre-shift shadow because both read shadow_q.
    always_comb begin
        shadow_d = load_i ? shadow_in_i : shadow_q;
        active_d = latch_i ? shadow_q : active_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        xe       = {(x_unsigned_i ? 1'b0 : x_i[DATA_WIDTH-1]), x_i};
        prod     = PW'(xe) * PW'($signed(active_q));
        prod_ext = {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};
`ifdef MAC_PE_SIMD_SAT_EN
        sum_wide = sat_add(64'(y_i), 64'(prod_ext), ACC_WIDTH);
        sum_o    = sum_wide[ACC_WIDTH-1:0];
`else
        sum_o    = y_i + prod_ext;
`endif
    end

    assign shadow_o = shadow_q;

endmodule

// File: rtl/mac_pe_simd.sv
// Systolic PE with LANES MAC lanes sharing one X activation; handshake, output regs, load count.
// Build with MAC_PE_SIMD_SAT_EN for saturating lane sums (timing is unchanged).
module mac_pe_simd
    import npu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = NPU_DATA_WIDTH,
    parameter int unsigned ACC_WIDTH  = NPU_ACC_WIDTH,
    parameter int unsigned LANES      = 4
) (
    input logic           clk,
    input logic           rst_n,
    mac_pe_simd_if.slave  bus
);
    localparam int unsigned CntW = $clog2(LANES + 1);

    logic stall_x, stall_y, fire_load, fire_calc;

    logic                       valid_out_x_q, valid_out_x_d;
    logic                       weight_shift_out_q, weight_shift_out_d;
    logic [DATA_WIDTH-1:0]      x_out_q, x_out_d;
    logic                       valid_out_y_q, valid_out_y_d;
    logic [LANES*ACC_WIDTH-1:0] y_out_q, y_out_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic                       shadow_full_q, shadow_full_d;

    logic [DATA_WIDTH-1:0]      chain [LANES+1];
    logic [LANES*ACC_WIDTH-1:0] sum_all;

    assign stall_x   = valid_out_x_q & ~bus.ready_in_x;
    assign stall_y   = valid_out_y_q & ~bus.ready_in_y;
    assign fire_load = bus.valid_in_x & bus.weight_shift_in & ~stall_x;
    assign fire_calc = bus.valid_in_x & bus.valid_in_y & ~bus.weight_shift_in & ~stall_x
                       & ~stall_y;

    assign chain[0] = bus.x_in;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mac_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .load_i      (fire_load),
            .latch_i     (bus.weight_latch_en),
            .x_unsigned_i(bus.x_unsigned),
            .shadow_in_i (chain[g]),
            .x_i         (bus.x_in),
            .y_i         (bus.y_in[`NPU_LANE(g, ACC_WIDTH)]),
            .shadow_o    (chain[g+1]),
            .sum_o       (sum_all[`NPU_LANE(g, ACC_WIDTH)])
        );
    end

    always_comb begin
        valid_out_x_d      = valid_out_x_q;
        weight_shift_out_d = weight_shift_out_q;
        x_out_d            = x_out_q;
        valid_out_y_d      = valid_out_y_q;
        y_out_d            = y_out_q;
        cnt_d              = cnt_q;

        if (fire_load) begin
            x_out_d            = chain[LANES];
            weight_shift_out_d = 1'b1;
            valid_out_x_d      = 1'b1;
            valid_out_y_d      = 1'b0;
        end else if (fire_calc) begin
            x_out_d            = bus.x_in;
            weight_shift_out_d = 1'b0;
            valid_out_x_d      = 1'b1;
            valid_out_y_d      = 1'b1;
            y_out_d            = sum_all;
        end else begin
            if (valid_out_x_q && bus.ready_in_x) valid_out_x_d = 1'b0;
            if (valid_out_y_q && bus.ready_in_y) valid_out_y_d = 1'b0;
        end

        // A load coinciding with a latch is the first token of the new batch.
        if (bus.weight_latch_en) begin
            cnt_d = fire_load ? CntW'(1) : '0;
        end else if (fire_load && (cnt_q != CntW'(LANES))) begin
            cnt_d = cnt_q + CntW'(1);
        end
        shadow_full_d = (cnt_d == CntW'(LANES));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out_x_q      <= 1'b0;
            weight_shift_out_q <= 1'b0;
            x_out_q            <= '0;
            valid_out_y_q      <= 1'b0;
            y_out_q            <= '0;
            cnt_q              <= '0;
            shadow_full_q      <= 1'b0;
        end else begin
            valid_out_x_q      <= valid_out_x_d;
            weight_shift_out_q <= weight_shift_out_d;
            x_out_q            <= x_out_d;
            valid_out_y_q      <= valid_out_y_d;
            y_out_q            <= y_out_d;
            cnt_q              <= cnt_d;
            shadow_full_q      <= shadow_full_d;
        end
    end

    assign bus.ready_out_x      = fire_load | fire_calc;
    assign bus.ready_out_y      = fire_calc;
    assign bus.valid_out_x      = valid_out_x_q;
    assign bus.weight_shift_out = weight_shift_out_q;
    assign bus.x_out            = x_out_q;
    assign bus.valid_out_y      = valid_out_y_q;
    assign bus.y_out            = y_out_q;
    assign bus.shadow_full      = shadow_full_q;

endmodule

// File: tb/tb_mac_pe_simd.sv
// Directed bench for mac_pe_simd (LANES=4); expected outputs queue up and a negedge monitor checks.
module tb_mac_pe_simd;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 32;
    localparam int unsigned L  = 4;

`ifdef MAC_PE_SIMD_SAT_EN
    localparam logic [31:0] POS_OVF = 32'h7FFF_FFFF;
    localparam logic [31:0] NEG_OVF = 32'h8000_0000;
`else
    localparam logic [31:0] POS_OVF = 32'h8000_0000;
    localparam logic [31:0] NEG_OVF = 32'h7FFF_FFFF;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [L*AW-1:0] yq [$];
    logic [DW:0]     xq [$];

    always #5 clk = ~clk;

    mac_pe_simd_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LANES(L)) bus ();

    mac_pe_simd #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LANES(L)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [DW-1:0] w, input logic [DW-1:0] evict, input logic latch);
        bus.valid_in_x      = 1'b1;
        bus.weight_shift_in = 1'b1;
        bus.x_in            = w;
        bus.weight_latch_en = latch;
        xq.push_back({1'b1, evict});
        tick();
        bus.valid_in_x      = 1'b0;
        bus.weight_shift_in = 1'b0;
        bus.weight_latch_en = 1'b0;
    endtask

    task automatic latch();
        bus.weight_latch_en = 1'b1;
        tick();
        bus.weight_latch_en = 1'b0;
    endtask

    task automatic calc(input logic [DW-1:0] x, input logic uns, input logic [L*AW-1:0] y,
                        input logic [L*AW-1:0] exp);
        bus.valid_in_x = 1'b1;
        bus.valid_in_y = 1'b1;
        bus.x_in       = x;
        bus.x_unsigned = uns;
        bus.y_in       = y;
        yq.push_back(exp);
        xq.push_back({1'b0, x});
        tick();
        bus.valid_in_x = 1'b0;
        bus.valid_in_y = 1'b0;
        bus.x_unsigned = 1'b0;
    endtask

    // Monitor: an output token is checked in the cycle it is consumed.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.valid_out_y && bus.ready_in_y) begin
                if (yq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL y_unexpected: got %h expected none", bus.y_out);
                end else begin
                    check("y_out", 128'(bus.y_out), 128'(yq.pop_front()));
                end
            end
            if (bus.valid_out_x && bus.ready_in_x) begin
                if (xq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL x_unexpected: got %h expected none",
                             {bus.weight_shift_out, bus.x_out});
                end else begin
                    check("x_out", 128'({bus.weight_shift_out, bus.x_out}),
                          128'(xq.pop_front()));
                end
            end
        end
    end

    initial begin
        bus.valid_in_x      = 1'b0;
        bus.weight_shift_in = 1'b0;
        bus.x_in            = '0;
        bus.ready_in_x      = 1'b1;
        bus.valid_in_y      = 1'b0;
        bus.y_in            = '0;
        bus.ready_in_y      = 1'b1;
        bus.weight_latch_en = 1'b0;
        bus.x_unsigned      = 1'b0;

        #3;
        check("rst_valid_out_x", 128'(bus.valid_out_x), 128'd0);
        check("rst_valid_out_y", 128'(bus.valid_out_y), 128'd0);
        check("rst_y_out", 128'(bus.y_out), 128'd0);
        check("rst_x_out", 128'({bus.weight_shift_out, bus.x_out}), 128'd0);
        check("rst_shadow_full", 128'(bus.shadow_full), 128'd0);
        #9;
        rst_n = 1'b1;
        tick();

        // Weights 1..4 shifted in; lane0 ends up with the last one.
        bus.valid_in_x      = 1'b1;
        bus.weight_shift_in = 1'b1;
        bus.x_in            = 8'd1;
        #1;
        check("load_ready_x", 128'(bus.ready_out_x), 128'd1);
        load(8'd1, 8'd0, 1'b0);
        load(8'd2, 8'd0, 1'b0);
        load(8'd3, 8'd0, 1'b0);
        check("full_after_3", 128'(bus.shadow_full), 128'd0);
        load(8'd4, 8'd0, 1'b0);
        check("full_after_4", 128'(bus.shadow_full), 128'd1);
        latch();
        check("full_after_latch", 128'(bus.shadow_full), 128'd0);

        // x=3 against weights {4,3,2,1}, y=10 per lane.
        calc(8'd3, 1'b0, {4{32'd10}}, {32'd13, 32'd16, 32'd19, 32'd22});
        check("calc_valid_x", 128'(bus.valid_out_x), 128'd1);
        check("calc_valid_y", 128'(bus.valid_out_y), 128'd1);
        tick();

        // Weight -1 everywhere; x=0xFF signed (-1) then unsigned (255).
        load(8'hFF, 8'd1, 1'b0);
        load(8'hFF, 8'd2, 1'b0);
        load(8'hFF, 8'd3, 1'b0);
        load(8'hFF, 8'd4, 1'b0);
        latch();
        calc(8'hFF, 1'b0, '0, {4{32'd1}});
        calc(8'hFF, 1'b1, '0, {4{32'hFFFF_FF01}});

        // Weight 1 everywhere; accumulator overflow in both directions.
        load(8'd1, 8'hFF, 1'b0);
        load(8'd1, 8'hFF, 1'b0);
        load(8'd1, 8'hFF, 1'b0);
        load(8'd1, 8'hFF, 1'b0);
        latch();
        calc(8'd1, 1'b0, {32'd5, 32'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF},
             {32'd6, 32'd1, POS_OVF, POS_OVF});
        calc(8'hFF, 1'b0, {32'h8000_0000, 32'd0, 32'd3, 32'd10},
             {NEG_OVF, 32'hFFFF_FFFF, 32'd2, 32'd9});
        tick();

        // Y stalled downstream: calc blocked, weight load still accepted.
        bus.ready_in_y = 1'b0;
        calc(8'd2, 1'b0, '0, {4{32'd2}});
        bus.valid_in_x = 1'b1;
        bus.valid_in_y = 1'b1;
        #1;
        check("stall_calc_ready_x", 128'(bus.ready_out_x), 128'd0);
        check("stall_calc_ready_y", 128'(bus.ready_out_y), 128'd0);
        bus.weight_shift_in = 1'b1;
        #1;
        check("stall_load_ready_x", 128'(bus.ready_out_x), 128'd1);
        check("stall_load_ready_y", 128'(bus.ready_out_y), 128'd0);
        bus.valid_in_x      = 1'b0;
        bus.valid_in_y      = 1'b0;
        bus.weight_shift_in = 1'b0;
        tick();
        tick();
        check("stall_hold_valid_y", 128'(bus.valid_out_y), 128'd1);
        bus.ready_in_y = 1'b1;
        tick();
        tick();

        // Latch coinciding with a load: pre-shift shadow {7,6,5,1} goes active, count restarts at 1.
        load(8'd5, 8'd1, 1'b0);
        load(8'd6, 8'd1, 1'b0);
        load(8'd7, 8'd1, 1'b0);
        load(8'd9, 8'd1, 1'b1);
        check("coinc_full", 128'(bus.shadow_full), 128'd0);
        load(8'd2, 8'd5, 1'b0);
        load(8'd2, 8'd6, 1'b0);
        load(8'd2, 8'd7, 1'b0);
        check("coinc_full_after_3", 128'(bus.shadow_full), 128'd1);
        calc(8'd1, 1'b0, '0, {32'd1, 32'd5, 32'd6, 32'd7});
        tick();

        // Asynchronous reset with a token in flight; that token is dropped.
        bus.valid_in_x = 1'b1;
        bus.valid_in_y = 1'b1;
        bus.x_in       = 8'd4;
        bus.y_in       = {4{32'd1}};
        tick();
        bus.valid_in_x = 1'b0;
        bus.valid_in_y = 1'b0;
        check("pre_rst_valid_y", 128'(bus.valid_out_y), 128'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid_x", 128'(bus.valid_out_x), 128'd0);
        check("mid_rst_valid_y", 128'(bus.valid_out_y), 128'd0);
        check("mid_rst_y_out", 128'(bus.y_out), 128'd0);
        check("mid_rst_x_out", 128'({bus.weight_shift_out, bus.x_out}), 128'd0);
        check("mid_rst_shadow_full", 128'(bus.shadow_full), 128'd0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 20 && (yq.size() != 0 || xq.size() != 0); i++) tick();
        check("yq_drained", 128'(yq.size()), 128'd0);
        check("xq_drained", 128'(xq.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
